// File: rtl/fp_add_sequencer_if.sv
// ============================================================================
// fp_add_sequencer_if : operand/result handshake bundle for fp_add_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fp_add_sequencer_if #(
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] op_a;
    logic [WORD_W-1:0] op_b;
    logic              op_symbol;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] result;
    logic              busy;

    modport slave (
        input  in_valid, op_a, op_b, op_symbol, out_ready,
        output in_ready, out_valid, result, busy
    );

    modport master (
        output in_valid, op_a, op_b, op_symbol, out_ready,
        input  in_ready, out_valid, result, busy
    );
endinterface

`default_nettype wire

// File: rtl/fp_add_sequencer.sv
// ============================================================================
// fp_add_sequencer : multi-cycle IEEE-754 single add/sub controller; optional FP_SPECIAL_EN (NaN/inf bypass)
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp_add_sequencer #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    fp_add_sequencer_if.slave      bus,
    output logic [EXP_W-1:0]       dp_diff_exp,
    output logic                   dp_sign_exp,
    output logic [FRAC_W:0]        dp_frac_a,
    output logic [FRAC_W:0]        dp_frac_b,
    output logic                   dp_sign_a,
    output logic                   dp_sign_b,
    output logic                   dp_symbol,
    input  wire logic [FRAC_W+1:0] dp_out,
    input  wire logic              dp_sign_out
);
    localparam int c_WORD_W = 1 + EXP_W + FRAC_W;
    localparam int c_F_W    = FRAC_W + 2;
    localparam int c_E_W    = EXP_W + 2;
    localparam logic [c_E_W-1:0] c_E_ONE = c_E_W'(1);
    localparam logic [c_E_W-1:0] c_E_MAX = c_E_W'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_EXEC  = 3'd2,
        S_NORM  = 3'd3,
        S_PACK  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                r_state;
    logic [c_WORD_W-1:0]   r_op_a;
    logic [c_WORD_W-1:0]   r_op_b;
    logic                  r_sym;
    logic [c_E_W-1:0]      r_e;
    logic [c_F_W-1:0]      r_f;
    logic                  r_s;
    logic                  r_zero;
    logic                  r_uflow;

    logic [EXP_W-1:0]      w_ea;
    logic [EXP_W-1:0]      w_eb;
    logic [EXP_W-1:0]      w_ea_eff;
    logic [EXP_W-1:0]      w_eb_eff;
    logic [EXP_W:0]        w_diff;
    logic [EXP_W:0]        w_diff_neg;
    logic                  w_b_larger;
    logic [EXP_W-1:0]      w_abs_diff;
    logic [FRAC_W:0]       w_frac_a;
    logic [FRAC_W:0]       w_frac_b;

    // Denormals are flushed: zero fraction, exponent treated as 1.
    assign w_ea       = r_op_a[c_WORD_W-2:FRAC_W];
    assign w_eb       = r_op_b[c_WORD_W-2:FRAC_W];
    assign w_ea_eff   = (w_ea == '0) ? EXP_W'(1) : w_ea;
    assign w_eb_eff   = (w_eb == '0) ? EXP_W'(1) : w_eb;
    assign w_diff     = {1'b0, w_ea_eff} - {1'b0, w_eb_eff};
    assign w_diff_neg = -w_diff;
    assign w_b_larger = w_diff[EXP_W];
    assign w_abs_diff = w_b_larger ? w_diff_neg[EXP_W-1:0] : w_diff[EXP_W-1:0];
    assign w_frac_a   = (w_ea == '0) ? '0 : {1'b1, r_op_a[FRAC_W-1:0]};
    assign w_frac_b   = (w_eb == '0) ? '0 : {1'b1, r_op_b[FRAC_W-1:0]};

`ifdef FP_SPECIAL_EN
    localparam logic [c_WORD_W-1:0] c_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    logic                  w_a_max;
    logic                  w_b_max;
    logic                  w_nan;
    logic                  w_special;
    logic [c_WORD_W-1:0]   w_special_res;
    logic                  r_special;
    logic [c_WORD_W-1:0]   r_special_res;

    assign w_a_max   = &w_ea;
    assign w_b_max   = &w_eb;
    assign w_special = w_a_max | w_b_max;
    assign w_nan     = (w_a_max && (|r_op_a[FRAC_W-1:0]))
                     | (w_b_max && (|r_op_b[FRAC_W-1:0]))
                     | (w_a_max && w_b_max && (r_op_a[c_WORD_W-1] ^ r_op_b[c_WORD_W-1] ^ r_sym));

    always_comb begin
        w_special_res = {r_op_b[c_WORD_W-1] ^ r_sym, r_op_b[c_WORD_W-2:0]};
        if (w_nan) begin
            w_special_res = c_QNAN;
        end else if (w_a_max) begin
            w_special_res = r_op_a;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.result    <= '0;
            dp_diff_exp   <= '0;
            dp_sign_exp   <= 1'b0;
            dp_frac_a     <= '0;
            dp_frac_b     <= '0;
            dp_sign_a     <= 1'b0;
            dp_sign_b     <= 1'b0;
            dp_symbol     <= 1'b0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_sym         <= 1'b0;
            r_e           <= '0;
            r_f           <= '0;
            r_s           <= 1'b0;
            r_zero        <= 1'b0;
            r_uflow       <= 1'b0;
`ifdef FP_SPECIAL_EN
            r_special     <= 1'b0;
            r_special_res <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_op_a       <= bus.op_a;
                        r_op_b       <= bus.op_b;
                        r_sym        <= bus.op_symbol;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        r_state      <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    dp_diff_exp <= w_abs_diff;
                    dp_sign_exp <= w_b_larger;
                    dp_frac_a   <= w_frac_a;
                    dp_frac_b   <= w_frac_b;
                    dp_sign_a   <= r_op_a[c_WORD_W-1];
                    dp_sign_b   <= r_op_b[c_WORD_W-1];
                    dp_symbol   <= r_sym;
                    r_e         <= c_E_W'(w_b_larger ? w_eb_eff : w_ea_eff);
                    r_zero      <= 1'b0;
                    r_uflow     <= 1'b0;
`ifdef FP_SPECIAL_EN
                    r_special     <= w_special;
                    r_special_res <= w_special_res;
                    r_state       <= w_special ? S_PACK : S_EXEC;
`else
                    r_state     <= S_EXEC;
`endif
                end
                S_EXEC: begin
                    r_f     <= dp_out;
                    r_s     <= dp_sign_out;
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    // One shift per cycle; the exit decision costs one extra cycle.
                    if (r_f == '0) begin
                        r_zero  <= 1'b1;
                        r_state <= S_PACK;
                    end else if (r_f[c_F_W-1]) begin
                        r_f <= r_f >> 1;
                        r_e <= r_e + c_E_ONE;
                    end else if (!r_f[FRAC_W]) begin
                        if (r_e > c_E_ONE) begin
                            r_f <= r_f << 1;
                            r_e <= r_e - c_E_ONE;
                        end else begin
                            r_uflow <= 1'b1;
                            r_state <= S_PACK;
                        end
                    end else begin
                        r_state <= S_PACK;
                    end
                end
                S_PACK: begin
`ifdef FP_SPECIAL_EN
                    if (r_special) begin
                        bus.result <= r_special_res;
                    end else
`endif
                    if (r_zero) begin
                        bus.result <= '0;
                    end else if (r_uflow) begin
                        bus.result <= {r_s, {(c_WORD_W-1){1'b0}}};
                    end else if (r_e >= c_E_MAX) begin
                        bus.result <= {r_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    end else begin
                        bus.result <= {r_s, r_e[EXP_W-1:0], r_f[FRAC_W-1:0]};
                    end
                    bus.out_valid <= 1'b1;
                    r_state       <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

`default_nettype wire
